// File: rtl/mp_control_unit.sv
// mp_control_unit: multi-cycle sequencer for the 16-bit MP datapath.
// Walks fetch/decode/execute/memory/writeback and drives every datapath
// strobe and select. It also handles the memory ready handshake, memory
// timeouts, illegal-opcode traps and the halt/run protocol.
module mp_control_unit #(
  parameter bit AUTO_RUN     = 1'b1,
  parameter int MEM_WAIT_MAX = 255
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Run,
  input  logic [15:0] Instr,
  input  logic        Mem_ready,
  input  logic        Zero,
  output logic        Mem_req,
  output logic        Mem_we,
  output logic        Addr_sel,
  output logic        Ir_load,
  output logic        Pc_inc,
  output logic        Pc_load,
  output logic [2:0]  Alu_op,
  output logic        Alu_src,
  output logic        Reg_we,
  output logic [1:0]  Wb_sel,
  output logic        Out_load,
  output logic        Halted,
  output logic [1:0]  Err,
  output logic [2:0]  State,
  output logic [15:0] Instr_count
);

  typedef enum logic [2:0] {
    ST_HALT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5
  } state_t;

  localparam state_t RESET_STATE = AUTO_RUN ? ST_FETCH : ST_HALT;

  // The last wait-counter value before a stalled handshake gives up.
  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_WAIT_MAX - 1);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_LDI  = 4'h5;
  localparam logic [3:0] OP_LD   = 4'h6;
  localparam logic [3:0] OP_ST   = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_IN   = 4'hA;
  localparam logic [3:0] OP_OUT  = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_ADD    = 3'b000;
  localparam logic [2:0] ALU_SUB    = 3'b001;
  localparam logic [2:0] ALU_AND    = 3'b010;
  localparam logic [2:0] ALU_OR     = 3'b011;
  localparam logic [2:0] ALU_PASS_B = 3'b100;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [1:0]  err;
  logic [15:0] instr_cnt;
  logic        retire;
  logic        wait_expired;
  logic [3:0]  opcode;
  logic        is_rtype;
  logic        is_illegal;
  logic        unused_instr_bits;

  // Register fields are decoded by the datapath, only the opcode matters here.
  assign opcode            = Instr[15:12];
  assign unused_instr_bits = ^Instr[11:0];

  assign is_rtype     = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                        (opcode == OP_AND) || (opcode == OP_OR);
  assign is_illegal   = (opcode == 4'hC) || (opcode == 4'hD) || (opcode == 4'hE);
  assign wait_expired = (wait_cnt == WAIT_LIMIT);

  assign State       = state;
  assign Err         = err;
  assign Instr_count = instr_cnt;
  assign Halted      = (state == ST_HALT);

  function automatic logic [2:0] rtype_alu(input logic [3:0] op);
    case (op)
      OP_SUB:  rtype_alu = ALU_SUB;
      OP_AND:  rtype_alu = ALU_AND;
      OP_OR:   rtype_alu = ALU_OR;
      default: rtype_alu = ALU_ADD;
    endcase
  endfunction

  // Flag the cycles in which an instruction completes architecturally.
  always_comb begin
    retire = 1'b0;
    case (state)
      ST_DECODE: retire = (opcode == OP_NOP) || (opcode == OP_HALT);
      ST_EXEC:   retire = (opcode == OP_BEQ) || (opcode == OP_JMP) || (opcode == OP_OUT);
      ST_MEM:    retire = Mem_ready && (opcode == OP_ST);
      ST_WB:     retire = 1'b1;
      default:   retire = 1'b0;
    endcase
  end

  // Sequencer: state, sticky error, handshake wait counter and retire count.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= RESET_STATE;
      wait_cnt  <= 8'd0;
      err       <= ERR_NONE;
      instr_cnt <= 16'd0;
    end else begin
      wait_cnt <= 8'd0;
      if (retire) begin
        instr_cnt <= instr_cnt + 16'd1;
      end
      case (state)
        ST_HALT: begin
          if (Run) begin
            state <= ST_FETCH;
            err   <= ERR_NONE;
          end
        end
        ST_FETCH: begin
          if (Mem_ready) begin
            state <= ST_DECODE;
          end else if (wait_expired) begin
            state <= ST_HALT;
            err   <= ERR_TIMEOUT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_DECODE: begin
          if (opcode == OP_NOP) begin
            state <= ST_FETCH;
          end else if (opcode == OP_HALT) begin
            state <= ST_HALT;
          end else if (is_illegal) begin
            state <= ST_HALT;
            err   <= ERR_ILLEGAL;
          end else begin
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (is_rtype || (opcode == OP_LDI) || (opcode == OP_IN)) begin
            state <= ST_WB;
          end else if ((opcode == OP_LD) || (opcode == OP_ST)) begin
            state <= ST_MEM;
          end else begin
            state <= ST_FETCH;
          end
        end
        ST_MEM: begin
          if (Mem_ready) begin
            state <= (opcode == OP_ST) ? ST_FETCH : ST_WB;
          end else if (wait_expired) begin
            state <= ST_HALT;
            err   <= ERR_TIMEOUT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_WB: begin
          state <= ST_FETCH;
        end
        default: begin
          state <= ST_HALT;
        end
      endcase
    end
  end

  // Datapath strobes, forced low while reset is held so a pending request drops at once.
  always_comb begin
    Mem_req  = 1'b0;
    Mem_we   = 1'b0;
    Addr_sel = 1'b0;
    Ir_load  = 1'b0;
    Pc_inc   = 1'b0;
    Pc_load  = 1'b0;
    Alu_op   = ALU_ADD;
    Alu_src  = 1'b0;
    Reg_we   = 1'b0;
    Wb_sel   = 2'b00;
    Out_load = 1'b0;
    if (Rst_n) begin
      case (state)
        ST_FETCH: begin
          Mem_req = 1'b1;
          if (Mem_ready) begin
            Ir_load = 1'b1;
            Pc_inc  = 1'b1;
          end
        end
        ST_EXEC: begin
          case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
              Alu_op  = rtype_alu(opcode);
              Alu_src = 1'b0;
            end
            OP_LD, OP_ST: begin
              Alu_op  = ALU_ADD;
              Alu_src = 1'b1;
            end
            OP_BEQ: begin
              Alu_op  = ALU_SUB;
              Alu_src = 1'b0;
              Pc_load = Zero;
            end
            OP_JMP: begin
              Alu_op  = ALU_PASS_B;
              Alu_src = 1'b1;
              Pc_load = 1'b1;
            end
            OP_OUT: begin
              Out_load = 1'b1;
            end
            default: begin
              Out_load = 1'b0;
            end
          endcase
        end
        ST_MEM: begin
          Mem_req  = 1'b1;
          Addr_sel = 1'b1;
          Alu_op   = ALU_ADD;
          Alu_src  = 1'b1;
          Mem_we   = (opcode == OP_ST);
        end
        ST_WB: begin
          Reg_we = 1'b1;
          case (opcode)
            OP_LD:   Wb_sel = 2'b01;
            OP_IN:   Wb_sel = 2'b10;
            OP_LDI:  Wb_sel = 2'b11;
            default: begin
              Wb_sel  = 2'b00;
              Alu_op  = rtype_alu(opcode);
              Alu_src = 1'b0;
            end
          endcase
        end
        default: begin
          Mem_req = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mp_control_unit.sv
// tb_mp_control_unit: directed bench for the MP sequencer. dut_a runs small
// programs against a behavioural datapath and memory. dut_b has a short
// memory timeout and powers up halted.
module tb_mp_control_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int misses  = 0;

  // dut_a signals
  logic        rst_n_a, run_a, ready_a, zero_a;
  logic [15:0] instr_a;
  logic        mem_req_a, mem_we_a, addr_sel_a, ir_load_a, pc_inc_a, pc_load_a;
  logic [2:0]  alu_op_a;
  logic        alu_src_a, reg_we_a, out_load_a, halted_a;
  logic [1:0]  wb_sel_a, err_a;
  logic [2:0]  state_a;
  logic [15:0] count_a;

  // dut_b signals
  logic        rst_n_b, run_b;
  logic        mem_req_b, mem_we_b, addr_sel_b, ir_load_b, pc_inc_b, pc_load_b;
  logic [2:0]  alu_op_b;
  logic        alu_src_b, reg_we_b, out_load_b, halted_b;
  logic [1:0]  wb_sel_b, err_b;
  logic [2:0]  state_b;
  logic [15:0] count_b;

  mp_control_unit #(.AUTO_RUN(1'b1), .MEM_WAIT_MAX(255)) dut_a (
    .Clk(clk), .Rst_n(rst_n_a), .Run(run_a), .Instr(instr_a),
    .Mem_ready(ready_a), .Zero(zero_a), .Mem_req(mem_req_a), .Mem_we(mem_we_a),
    .Addr_sel(addr_sel_a), .Ir_load(ir_load_a), .Pc_inc(pc_inc_a), .Pc_load(pc_load_a),
    .Alu_op(alu_op_a), .Alu_src(alu_src_a), .Reg_we(reg_we_a), .Wb_sel(wb_sel_a),
    .Out_load(out_load_a), .Halted(halted_a), .Err(err_a), .State(state_a),
    .Instr_count(count_a)
  );

  mp_control_unit #(.AUTO_RUN(1'b0), .MEM_WAIT_MAX(4)) dut_b (
    .Clk(clk), .Rst_n(rst_n_b), .Run(run_b), .Instr(16'h0000),
    .Mem_ready(1'b0), .Zero(1'b0), .Mem_req(mem_req_b), .Mem_we(mem_we_b),
    .Addr_sel(addr_sel_b), .Ir_load(ir_load_b), .Pc_inc(pc_inc_b), .Pc_load(pc_load_b),
    .Alu_op(alu_op_b), .Alu_src(alu_src_b), .Reg_we(reg_we_b), .Wb_sel(wb_sel_b),
    .Out_load(out_load_b), .Halted(halted_b), .Err(err_b), .State(state_b),
    .Instr_count(count_b)
  );

  // Behavioural datapath for dut_a: rd=[11:9], rs=[8:6], rt=[5:3], imm=[5:0].
  logic [15:0] mem [0:255];
  logic [15:0] regs [0:7];
  logic [15:0] pc = 16'd0, ir = 16'd0, mdr = 16'd0, dout = 16'd0;
  logic [15:0] imm, op_a, op_b, alu_res, addr, rdata, wb_data, target;

  always_comb begin
    imm  = {10'd0, ir[5:0]};
    op_a = regs[ir[8:6]];
    op_b = alu_src_a ? imm : regs[ir[5:3]];
    case (alu_op_a)
      3'b000:  alu_res = op_a + op_b;
      3'b001:  alu_res = op_a - op_b;
      3'b010:  alu_res = op_a & op_b;
      3'b011:  alu_res = op_a | op_b;
      3'b100:  alu_res = op_b;
      default: alu_res = 16'd0;
    endcase
    addr  = addr_sel_a ? alu_res : pc;
    rdata = mem[addr[7:0]];
    case (wb_sel_a)
      2'b00:   wb_data = alu_res;
      2'b01:   wb_data = mdr;
      2'b10:   wb_data = 16'h00A5;
      default: wb_data = imm;
    endcase
    target = (ir[15:12] == 4'h8) ? {10'd0, ir[11:9], 3'd0} : alu_res;
  end

  assign zero_a  = (alu_res == 16'd0);
  assign instr_a = ir;

  always @(posedge clk) begin
    if (ir_load_a) ir <= rdata;
    if (mem_req_a && ready_a) mdr <= rdata;
    if (pc_inc_a) pc <= pc + 16'd1;
    if (pc_load_a) pc <= target;
    if (mem_req_a && mem_we_a && ready_a) mem[addr[7:0]] <= regs[ir[11:9]];
    if (reg_we_a) regs[ir[11:9]] <= wb_data;
    if (out_load_a) dout <= regs[ir[11:9]];
  end

  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    vectors++;
    if (actual !== expected) begin
      misses++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rdy);
    @(negedge clk);
    ready_a = rdy;
    #1;
  endtask

  task automatic runPulseA();
    @(negedge clk);
    run_a = 1'b1;
    @(posedge clk);
    #1 run_a = 1'b0;
  endtask

  task automatic runPulseB();
    @(negedge clk);
    run_b = 1'b1;
    @(posedge clk);
    #1 run_b = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int we_cyc[$];
    int out_cyc, mem_cyc, wb_cyc;
    logic [1:0] wb_seen;

    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 8; i++) regs[i] = 16'h0000;
    mem[0]  = 16'h5205;  // LDI r1,5
    mem[1]  = 16'h5403;  // LDI r2,3
    mem[2]  = 16'h1650;  // ADD r3,r1,r2
    mem[3]  = 16'hB600;  // OUT r3
    mem[4]  = 16'hF000;  // HALT
    mem[5]  = 16'h684A;  // LD r4,[r1+10]
    mem[6]  = 16'hF000;  // HALT
    mem[7]  = 16'h8050;  // BEQ r1,r2 (not taken)
    mem[8]  = 16'h8448;  // BEQ r1,r1 -> 16
    mem[15] = 16'h1234;  // LD data
    mem[16] = 16'h0000;  // NOP
    mem[17] = 16'hD000;  // illegal
    mem[18] = 16'h0000;  // NOP
    mem[19] = 16'hF000;  // HALT
    mem[20] = 16'h7854;  // ST r4,[r1+20]

    rst_n_a = 1'b0; rst_n_b = 1'b0; run_a = 1'b0; run_b = 1'b0; ready_a = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_a_state", {13'd0, state_a}, 16'd1);
    checkOutput("rst_a_mem_req", {15'd0, mem_req_a}, 16'd0);
    checkOutput("rst_a_halted", {15'd0, halted_a}, 16'd0);
    checkOutput("rst_a_err", {14'd0, err_a}, 16'd0);
    checkOutput("rst_a_count", count_a, 16'd0);
    checkOutput("rst_b_state", {13'd0, state_b}, 16'd0);
    checkOutput("rst_b_halted", {15'd0, halted_b}, 16'd1);
    checkOutput("rst_b_mem_req", {15'd0, mem_req_b}, 16'd0);

    @(posedge clk);
    #2 rst_n_a = 1'b1; rst_n_b = 1'b1;

    // Program: LDI, LDI, ADD, OUT, HALT with memory always ready
    out_cyc = 0;
    for (int c = 1; c <= 18; c++) begin
      applyStimulus(1'b1);
      if (reg_we_a) we_cyc.push_back(c);
      if (out_load_a) out_cyc = c;
      if (c == 16) begin
        checkOutput("prog_count", count_a, 16'd4);
        checkOutput("prog_dout", dout, 16'h0008);
      end
    end
    checkOutput("prog_we_pulses", 16'(we_cyc.size()), 16'd3);
    for (int i = 0; i < 3; i++)
      checkOutput("prog_we_cycle", (i < we_cyc.size()) ? 16'(we_cyc[i]) : 16'd0, 16'(4 * (i + 1)));
    checkOutput("prog_out_cycle", 16'(out_cyc), 16'd15);
    checkOutput("prog_halted", {15'd0, halted_a}, 16'd1);
    checkOutput("prog_count_halt", count_a, 16'd5);
    checkOutput("b_still_halted", {15'd0, halted_b}, 16'd1);

    // Fetch timeout on dut_b, then Run clears the error
    mem_cyc = 0;
    runPulseB();
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      #1;
      if (mem_req_b && !addr_sel_b) mem_cyc++;
    end
    checkOutput("to_fetch_cycles", 16'(mem_cyc), 16'd4);
    checkOutput("to_halted", {15'd0, halted_b}, 16'd1);
    checkOutput("to_err", {14'd0, err_b}, 16'd2);
    checkOutput("to_count", count_b, 16'd0);
    runPulseB();
    @(negedge clk);
    #1;
    checkOutput("to_run_state", {13'd0, state_b}, 16'd1);
    checkOutput("to_run_err", {14'd0, err_b}, 16'd0);

    // LD with ready withheld for ten MEM cycles
    mem_cyc = 0; wb_cyc = 0; wb_seen = 2'b00;
    runPulseA();
    for (int c = 1; c <= 18; c++) begin
      applyStimulus((c >= 4 && c <= 13) ? 1'b0 : 1'b1);
      if (mem_req_a && addr_sel_a && alu_src_a && alu_op_a == 3'b000 && !mem_we_a) mem_cyc++;
      if (reg_we_a) begin
        wb_cyc  = c;
        wb_seen = wb_sel_a;
      end
    end
    checkOutput("ld_mem_cycles", 16'(mem_cyc), 16'd11);
    checkOutput("ld_wb_cycle", 16'(wb_cyc), 16'd15);
    checkOutput("ld_wb_sel", {14'd0, wb_seen}, 16'd1);
    checkOutput("ld_r4", regs[4], 16'h1234);
    checkOutput("ld_count", count_a, 16'd7);

    // BEQ not taken, BEQ taken, NOP, illegal opcode
    runPulseA();
    for (int c = 1; c <= 11; c++) begin
      applyStimulus(1'b1);
      if (c == 3) checkOutput("beq_nt_pc_load", {15'd0, pc_load_a}, 16'd0);
      if (c == 4) checkOutput("beq_nt_retire", count_a, 16'd8);
      if (c == 6) checkOutput("beq_t_pc_load", {15'd0, pc_load_a}, 16'd1);
      if (c == 7) checkOutput("beq_t_pc", pc, 16'd16);
    end
    checkOutput("ill_halted", {15'd0, halted_a}, 16'd1);
    checkOutput("ill_err", {14'd0, err_a}, 16'd1);
    checkOutput("ill_count", count_a, 16'd10);

    // Counter wrap: preset to FFFF, then a NOP retires
    @(negedge clk);
    force dut_a.instr_cnt = 16'hFFFF;
    #1 release dut_a.instr_cnt;
    #1 checkOutput("wrap_preset", count_a, 16'hFFFF);
    runPulseA();
    for (int c = 1; c <= 5; c++) begin
      applyStimulus(1'b1);
      if (c == 1) checkOutput("run_clears_err", {14'd0, err_a}, 16'd0);
      if (c == 3) checkOutput("wrap_count", count_a, 16'h0000);
    end
    checkOutput("wrap_halt_count", count_a, 16'h0001);

    // ST stalled in MEM, then asynchronous reset
    runPulseA();
    for (int c = 1; c <= 4; c++) applyStimulus((c == 4) ? 1'b0 : 1'b1);
    checkOutput("st_state", {13'd0, state_a}, 16'd4);
    checkOutput("st_mem_we", {15'd0, mem_we_a}, 16'd1);
    checkOutput("st_mem_req", {15'd0, mem_req_a}, 16'd1);
    #1 rst_n_a = 1'b0;
    #1;
    checkOutput("arst_mem_req", {15'd0, mem_req_a}, 16'd0);
    checkOutput("arst_mem_we", {15'd0, mem_we_a}, 16'd0);
    checkOutput("arst_state", {13'd0, state_a}, 16'd1);
    checkOutput("arst_count", count_a, 16'd0);
    repeat (2) @(negedge clk);
    checkOutput("arst_no_write", mem[25], 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
